gbc_lcd_sampler: RTL and testbench
==================================

# gbc_lcd_sampler

Samples the Game Boy Color LCD bus (DCLK, CLS, SPS, 3-bit pixel data) in the pixel-clock domain. Tracks the current column and row and emits one-cycle VRAM write strobes with a linear address and an RGB332 colour byte. Sits directly upstream of the VGA frame-buffer SRAM write port. Because all writes happen in one clock domain, the VRAM becomes a single-clock dual-port memory.

## Interface
- H_PIXELS, 160, visible pixels per GBC line
- V_LINES, 144, visible lines per GBC frame
- ADDR_WIDTH, 15, VRAM address width
- i_clk  in  1  sampling/system clock (pixel clock); every register is clocked on its rising edge
- i_reset  in  1  asynchronous, active-high reset
- i_gbcDCLK  in  1  GBC dot clock, asynchronous to i_clk
- i_gbcCLS  in  1  GBC line latch/start pulse, asynchronous
- i_gbcSPS  in  1  GBC frame start, active-low, asynchronous
- i_gbcPixelData  in  3  GBC pixel intensity, asynchronous
- o_vramWriteAddr  out  ADDR_WIDTH  row*H_PIXELS + col
- o_vramDataOut  out  8  RGB332 byte
- o_vramWriteEnable  out  1  one-cycle write strobe
- o_frameStart  out  1  one-cycle pulse on each accepted frame start
- o_frameCount  out  8  frames started since reset; wraps 255→0
- o_lineLengthError  out  1  sticky: some line did not carry exactly H_PIXELS pixels

## Operation
- Synchronisation: all 6 input bits pass through a 2-flop synchronizer. A third register holds the previous synchronized DCLK/CLS/SPS values for edge detection. Pixel data is taken from the same 2nd synchronizer stage as DCLK.
- Events, evaluated every cycle on synchronized signals:
  - frame = SPS falling edge
  - line = CLS rising edge
  - pix = DCLK falling edge
- State machine:
  - IDLE: out of reset. All events are ignored except frame. frame → ACTIVE.
  - ACTIVE: on frame, set row=0, col=0, first_line=1, pulse o_frameStart, increment o_frameCount.
  - ACTIVE, on line without frame:
    - If first_line: clear first_line; row stays.
    - Else: if col != H_PIXELS, set o_lineLengthError; then row ← row+1, saturating at V_LINES.
    - In both cases col ← 0.
  - ACTIVE, on pix: if col < H_PIXELS and row < V_LINES:
    - o_vramWriteEnable=1
    - o_vramWriteAddr = line_base + col
    - o_vramDataOut = {p, p, p[2:1]}, where p is the synchronized pixel value
  - On pix, col ← col+1 regardless of bounds, saturating at 255. Out-of-bounds pixels are dropped without a write.
- Address arithmetic:
  - line_base is a register: 0 on frame; += H_PIXELS on each row increment. No multiplier.
  - Max address is 160*144−1 = 23039, which fits in 15 bits.
- Simultaneous events, applied in the same cycle in this order:
  - frame, then line, then pix.
  - frame+line: treated as frame only; first_line is cleared, so the next line increments the row.
  - line+pix: the pixel is written at col 0 of the updated row.
  - frame+pix: the pixel is written at row 0, col 0.
- Reset, asserted any time including mid-line: all registers clear, state returns to IDLE, and no write strobe is issued until the next frame.

## Timing
- Reset values: every output is 0; state=IDLE; col=row=line_base=0; first_line=0; all synchronizer flops 0.
- Latency: a DCLK falling edge reaches o_vramWriteEnable 3 i_clk rising edges later (2 synchronizer stages + 1 output register). CLS and SPS have the same latency.
- Output registering:
  - Address, data and enable are registered and valid in the same cycle as the strobe.
  - Between strobes, address and data hold their last value.
- Input requirement: DCLK high and low phases each last ≥3 i_clk periods; CLS and SPS pulse widths are ≥3 periods. Narrower pulses may be missed; this is not detected.
- Write throughput: at most one write per 6 i_clk cycles.

## Test plan
- Reset, then 160 DCLK falls with no SPS → o_vramWriteEnable never asserts; outputs stay 0.
- SPS fall, CLS rise, 160 DCLK falls with pixel=3'b101 → 160 strobes at addr 0..159, data 8'hB6, each 3 cycles after the DCLK fall; o_frameCount=1; no error.
- Full frame: 144 lines × 160 pixels → last strobe at addr 23039; a 145th line produces no writes.
- Short line of 150 pixels, then CLS → o_lineLengthError=1 and stays 1 through the next frame. The next line's first write is at addr 160.
- CLS rise coincident with a DCLK fall on line 2 → pixel written at addr 160 (row 1, col 0).
- Reset asserted mid-line 10 → outputs 0 immediately (asynchronous). After release, no writes occur until the next SPS fall; the first write after it is at addr 0.

Source files
------------

// File: rtl/gbc_lcd_sampler.sv
// GBC LCD bus sampler: synchronises the asynchronous LCD bus into the pixel clock domain and
// turns dot-clock falls into linear VRAM write strobes carrying an RGB332 byte.
module gbc_lcd_sampler #(
  parameter int unsigned H_PIXELS   = 160,
  parameter int unsigned V_LINES    = 144,
  parameter int unsigned ADDR_WIDTH = 15
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_gbcDCLK,
  input  logic                  i_gbcCLS,
  input  logic                  i_gbcSPS,
  input  logic [2:0]            i_gbcPixelData,
  output logic [ADDR_WIDTH-1:0] o_vramWriteAddr,
  output logic [7:0]            o_vramDataOut,
  output logic                  o_vramWriteEnable,
  output logic                  o_frameStart,
  output logic [7:0]            o_frameCount,
  output logic                  o_lineLengthError
);

  localparam logic [7:0]            HPix  = 8'(H_PIXELS);
  localparam logic [7:0]            VLin  = 8'(V_LINES);
  localparam logic [ADDR_WIDTH-1:0] HStep = ADDR_WIDTH'(H_PIXELS);

  typedef enum logic [0:0] {StIdle, StActive} state_e;

  // Bit layout of the synchroniser: {dclk, cls, sps, pixel[2:0]}
  logic [5:0] sync1_q, sync2_q;
  logic [2:0] prev_q;

  logic       dclk_s, cls_s, sps_s;
  logic [2:0] pix_s;
  logic       frame_ev, line_ev, pix_ev, active;

  state_e                state_q, state_d;
  logic [7:0]            col_q, col_d;
  logic [7:0]            row_q, row_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic                  first_q, first_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            data_q, data_d;
  logic                  we_q, we_d;
  logic                  fs_q, fs_d;
  logic [7:0]            fc_q, fc_d;
  logic                  err_q, err_d;

  assign dclk_s = sync2_q[5];
  assign cls_s  = sync2_q[4];
  assign sps_s  = sync2_q[3];
  assign pix_s  = sync2_q[2:0];

  assign frame_ev = prev_q[0] & ~sps_s;
  assign line_ev  = ~prev_q[1] & cls_s;
  assign pix_ev   = prev_q[2] & ~dclk_s;
  assign active   = (state_q == StActive) || frame_ev;

  always_comb begin
    state_d = state_q;
    col_d   = col_q;
    row_d   = row_q;
    base_d  = base_q;
    first_d = first_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    fs_d    = 1'b0;
    fc_d    = fc_q;
    err_d   = err_q;

    // Events are applied in order frame, line, pix; later stages see the updated position.
    if (frame_ev) begin
      state_d = StActive;
      col_d   = 8'd0;
      row_d   = 8'd0;
      base_d  = '0;
      first_d = ~line_ev;
      fs_d    = 1'b1;
      fc_d    = fc_q + 8'd1;
    end else if (active && line_ev) begin
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        if (col_q != HPix) err_d = 1'b1;
        if (row_q != VLin) begin
          row_d  = row_q + 8'd1;
          base_d = base_q + HStep;
        end
      end
      col_d = 8'd0;
    end

    if (active && pix_ev) begin
      if (col_d < HPix && row_d < VLin) begin
        we_d   = 1'b1;
        addr_d = base_d + ADDR_WIDTH'(col_d);
        data_d = {pix_s, pix_s, pix_s[2:1]};
      end
      if (col_d != 8'hff) col_d = col_d + 8'd1;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      state_q <= StIdle;
      col_q   <= '0;
      row_q   <= '0;
      base_q  <= '0;
      first_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      we_q    <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      sync1_q <= {i_gbcDCLK, i_gbcCLS, i_gbcSPS, i_gbcPixelData};
      sync2_q <= sync1_q;
      prev_q  <= {dclk_s, cls_s, sps_s};
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      base_q  <= base_d;
      first_q <= first_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      we_q    <= we_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
      err_q   <= err_d;
    end
  end

  assign o_vramWriteAddr   = addr_q;
  assign o_vramDataOut     = data_q;
  assign o_vramWriteEnable = we_q;
  assign o_frameStart      = fs_q;
  assign o_frameCount      = fc_q;
  assign o_lineLengthError = err_q;

endmodule

// File: tb/tb_gbc_lcd_sampler.sv
// Scoreboard bench for gbc_lcd_sampler: a bus driver records the expected write for every
// dot-clock fall and a negedge monitor checks address, data and 3-cycle latency of each strobe.
module tb_gbc_lcd_sampler;

  localparam int unsigned H  = 160;
  localparam int unsigned V  = 144;
  localparam int unsigned AW = 15;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          dclk = 1'b1;
  logic          cls = 1'b0;
  logic          sps = 1'b1;
  logic [2:0]    pdata = 3'd0;
  logic [AW-1:0] addr;
  logic [7:0]    data;
  logic          we;
  logic          fs;
  logic [7:0]    fcount;
  logic          lerr;

  gbc_lcd_sampler #(
    .H_PIXELS  (H),
    .V_LINES   (V),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk            (clk),
    .i_reset          (rst),
    .i_gbcDCLK        (dclk),
    .i_gbcCLS         (cls),
    .i_gbcSPS         (sps),
    .i_gbcPixelData   (pdata),
    .o_vramWriteAddr  (addr),
    .o_vramDataOut    (data),
    .o_vramWriteEnable(we),
    .o_frameStart     (fs),
    .o_frameCount     (fcount),
    .o_lineLengthError(lerr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_count = 0;
  int fs_count = 0;
  int last_addr = -1;

  // Reference bus model, written from the interface behaviour
  bit m_active = 0;
  bit m_first  = 0;
  bit m_err    = 0;
  int m_row = 0;
  int m_col = 0;
  int m_fc  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
               tag, got, got, exp, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic m_frame();
    m_active = 1;
    m_row    = 0;
    m_col    = 0;
    m_first  = 1;
    m_fc     = (m_fc + 1) % 256;
  endtask

  task automatic m_line();
    if (!m_active) return;
    if (m_first) m_first = 0;
    else begin
      if (m_col != H) m_err = 1;
      if (m_row < V) m_row++;
    end
    m_col = 0;
  endtask

  task automatic m_pix(input logic [2:0] p);
    exp_t e;
    logic [7:0] d;
    if (!m_active) return;
    if (m_col < H && m_row < V) begin
      d      = {p, p, p[2:1]};
      e.addr = m_row * H + m_col;
      e.data = int'(d);
      e.cyc  = cyc + 3;
      exp_q.push_back(e);
    end
    if (m_col < 255) m_col++;
  endtask

  task automatic drive_pix(input logic [2:0] p);
    pdata = p;
    dclk  = 1'b0;
    m_pix(p);
    tick(3);
    dclk = 1'b1;
    tick(3);
  endtask

  task automatic drive_line();
    cls = 1'b1;
    m_line();
    tick(3);
    cls = 1'b0;
    tick(3);
  endtask

  task automatic drive_frame();
    sps = 1'b0;
    m_frame();
    tick(3);
    sps = 1'b1;
    tick(3);
  endtask

  task automatic drive_line_pix(input logic [2:0] p);
    cls   = 1'b1;
    dclk  = 1'b0;
    pdata = p;
    m_line();
    m_pix(p);
    tick(3);
    cls  = 1'b0;
    dclk = 1'b1;
    tick(3);
  endtask

  task automatic drive_frame_pix(input logic [2:0] p);
    sps   = 1'b0;
    dclk  = 1'b0;
    pdata = p;
    m_frame();
    m_pix(p);
    tick(3);
    sps  = 1'b1;
    dclk = 1'b1;
    tick(3);
  endtask

  task automatic drive_pixels(input int n, input bit rand_p, input logic [2:0] p);
    for (int i = 0; i < n; i++) drive_pix(rand_p ? 3'($urandom_range(0, 7)) : p);
  endtask

  task automatic check_status(input string tag);
    check_eq({tag, "_fcount"}, fcount, m_fc);
    check_eq({tag, "_fs_pulses"}, fs_count, m_fc);
    check_eq({tag, "_lerr"}, lerr, m_err);
    check_eq({tag, "_pending"}, exp_q.size(), 0);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (fs) fs_count++;
      if (we) begin
        wr_count++;
        last_addr = int'(addr);
        if (exp_q.size() == 0) begin
          check_eq("spurious_write", {17'd0, addr}, 32'hffff_ffff);
        end else begin
          mon_e = exp_q.pop_front();
          check_eq("wr_addr", addr, mon_e.addr);
          check_eq("wr_data", data, mon_e.data);
          check_eq("wr_latency", cyc, mon_e.cyc);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

  int wc;

  initial begin
    // Reset state
    tick(3);
    check_eq("rst_we", we, 0);
    check_eq("rst_addr", addr, 0);
    check_eq("rst_data", data, 0);
    check_eq("rst_fs", fs, 0);
    check_eq("rst_fcount", fcount, 0);
    check_eq("rst_lerr", lerr, 0);
    rst = 1'b0;
    tick(4);

    // Dot clocks before any frame start are ignored
    drive_line();
    drive_pixels(H, 0, 3'b111);
    check_eq("idle_writes", wr_count, 0);
    check_eq("idle_addr", addr, 0);
    check_eq("idle_data", data, 0);

    // Frame 1: one clean line of 3'b101 -> data 8'hB6 at 0..159
    drive_frame();
    drive_line();
    drive_pixels(H, 0, 3'b101);
    check_eq("line0_writes", wr_count, H);
    check_eq("line0_last_addr", last_addr, H - 1);
    check_eq("hold_addr", addr, H - 1);
    check_eq("hold_data", data, 8'hB6);
    check_status("f1");

    // Frame 2: CLS rise coincident with a DCLK fall lands at row 1 col 0
    drive_frame();
    drive_line();
    drive_pixels(H, 1, 3'd0);
    drive_line_pix(3'b011);
    drive_pixels(H - 1, 1, 3'd0);
    check_eq("coincide_last_addr", last_addr, 2 * H - 1);
    check_status("f2");

    // Frame 3: short line raises the sticky error; next line starts at 160
    drive_frame();
    drive_line();
    drive_pixels(150, 1, 3'd0);
    drive_line();
    check_eq("short_lerr", lerr, 1);
    drive_pixels(5, 1, 3'd0);
    check_eq("short_next_addr", last_addr, H + 4);
    check_status("f3");

    // Frame 4: error survives a frame start; fast-forward rows to reach the last address
    drive_frame();
    check_eq("lerr_sticky", lerr, 1);
    drive_line();
    for (int i = 0; i < V - 1; i++) drive_line();
    drive_pixels(H, 1, 3'd0);
    check_eq("last_addr", last_addr, H * V - 1);
    wc = wr_count;
    drive_line();
    drive_pixels(10, 1, 3'd0);
    drive_line();
    drive_pixels(3, 1, 3'd0);
    check_eq("row_saturate_no_write", wr_count, wc);
    check_status("f4");

    // Frame 5: SPS fall coincident with a DCLK fall writes at address 0
    drive_frame_pix(3'b011);
    check_eq("frame_pix_addr", last_addr, 0);
    check_eq("frame_pix_data", data, 8'h6D);
    check_status("f5");

    // Frame 6: reset in the middle of line 10
    drive_frame();
    drive_line();
    for (int i = 0; i < 9; i++) drive_line();
    drive_pixels(20, 1, 3'd0);
    check_eq("pre_reset_addr", addr, 9 * H + 19);
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_addr", addr, 0);
    check_eq("async_rst_fcount", fcount, 0);
    check_eq("async_rst_lerr", lerr, 0);
    check_eq("async_rst_data", data, 0);
    m_active = 0;
    m_first  = 0;
    m_err    = 0;
    m_fc     = 0;
    m_row    = 0;
    m_col    = 0;
    fs_count = 0;
    tick(2);
    rst = 1'b0;
    tick(3);
    wc = wr_count;
    drive_line();
    drive_pixels(20, 1, 3'd0);
    check_eq("post_reset_no_write", wr_count, wc);
    drive_frame();
    drive_line();
    drive_pixels(4, 0, 3'b110);
    check_eq("post_reset_first_addr", last_addr, 3);
    check_status("f_after_reset");

    tick(5);
    check_eq("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
